// File: rtl/prog_loader_pkg.sv
// Shared command encodings and FSM state type for the program loader.
package prog_loader_pkg;

    localparam logic [1:0] CMD_DATA    = 2'b00;
    localparam logic [1:0] CMD_SETADDR = 2'b01;
    localparam logic [1:0] CMD_RUN     = 2'b10;
    localparam logic [1:0] CMD_HALT    = 2'b11;

    typedef enum logic [1:0] {
        ST_HALT  = 2'b00,
        ST_WRITE = 2'b01,
        ST_RUN   = 2'b10
    } state_t;

endpackage

// File: rtl/prog_loader_packer.sv
// Byte-lane packer: assembles little-endian bytes into one INST_W-bit word.
module prog_loader_packer #(
    parameter int INST_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic [7:0]        byte_in,
    output logic [INST_W-1:0] word,
    output logic              word_done
);

    localparam int LANES = INST_W / 8;
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    logic [IDX_W-1:0]  byte_idx_r;
    logic [INST_W-1:0] word_r;

    assign word_done = load & (byte_idx_r == LAST_IDX);
    assign word      = word_r;

    // Lane storage and byte index; stale lanes after a clear are overwritten before reuse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_idx_r <= {IDX_W{1'b0}};
            word_r     <= {INST_W{1'b0}};
        end else if (clear) begin
            byte_idx_r <= {IDX_W{1'b0}};
        end else if (load) begin
            word_r[{byte_idx_r, 3'b000} +: 8] <= byte_in;
            byte_idx_r <= word_done ? {IDX_W{1'b0}} : byte_idx_r + IDX_W'(1);
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Program loader: byte stream -> instruction memory writes, with CPU run/halt gating.
// Optional feature macro: PROG_LOADER_CHECKSUM_EN (running byte checksum).
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int INST_W = 16,
    parameter int DEPTH  = 128,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [1:0]        in_cmd,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [INST_W-1:0] mem_wdata,
    input  logic              mem_ready,
    output logic              cpu_run,
    output logic [ADDR_W:0]   words_loaded,
    output logic              err_overrun,
    output logic [7:0]        checksum
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    state_t            state_r;
    state_t            state_s;
    logic              in_ready_r;
    logic              mem_we_r;
    logic              cpu_run_r;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W:0]   words_r;
    logic              err_r;

    logic              xfer_s;
    logic              ack_s;
    logic              pk_load_s;
    logic              pk_clear_s;
    logic              set_addr_s;
    logic              err_set_s;
    logic              word_done_s;
    logic [INST_W-1:0] word_s;
    logic [ADDR_W-1:0] set_val_s;

    assign xfer_s = in_valid & in_ready_r;
    assign ack_s  = mem_we_r & mem_ready;

    // Address bytes arrive MSB-first; each SETADDR shifts the previous value up by 8
    generate
        if (ADDR_W <= 8) begin : g_addr_narrow
            assign set_val_s = in_data[ADDR_W-1:0];
        end else begin : g_addr_wide
            assign set_val_s = {addr_r[ADDR_W-9:0], in_data};
        end
    endgenerate

    prog_loader_packer #(.INST_W(INST_W)) u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (pk_clear_s),
        .load      (pk_load_s),
        .byte_in   (in_data),
        .word      (word_s),
        .word_done (word_done_s)
    );

    // Next-state and per-cycle control decode
    always_comb begin
        state_s    = state_r;
        pk_load_s  = 1'b0;
        pk_clear_s = 1'b0;
        set_addr_s = 1'b0;
        err_set_s  = 1'b0;
        case (state_r)
            ST_HALT: begin
                if (xfer_s) begin
                    case (in_cmd)
                        CMD_DATA: begin
                            pk_load_s = 1'b1;
                            if (word_done_s) begin
                                state_s = ST_WRITE;
                            end else begin
                                state_s = ST_HALT;
                            end
                        end
                        CMD_SETADDR: begin
                            set_addr_s = 1'b1;
                            pk_clear_s = 1'b1;
                        end
                        CMD_RUN: begin
                            pk_clear_s = 1'b1;
                            state_s    = ST_RUN;
                        end
                        CMD_HALT: state_s = ST_HALT;
                        default:  state_s = ST_HALT;
                    endcase
                end else begin
                    state_s = ST_HALT;
                end
            end
            ST_WRITE: begin
                if (ack_s) begin
                    state_s = ST_HALT;
                end else begin
                    state_s = ST_WRITE;
                end
            end
            ST_RUN: begin
                if (xfer_s) begin
                    case (in_cmd)
                        CMD_HALT:    state_s   = ST_HALT;
                        CMD_DATA:    err_set_s = 1'b1;
                        CMD_SETADDR: err_set_s = 1'b1;
                        default:     state_s   = ST_RUN;
                    endcase
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: state_s = ST_HALT;
        endcase
    end

    // Control state, registered handshake outputs, address and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_HALT;
            in_ready_r <= 1'b0;
            mem_we_r   <= 1'b0;
            cpu_run_r  <= 1'b0;
            addr_r     <= {ADDR_W{1'b0}};
            words_r    <= {(ADDR_W + 1){1'b0}};
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            in_ready_r <= (state_s != ST_WRITE);
            mem_we_r   <= (state_s == ST_WRITE);
            cpu_run_r  <= (state_s == ST_RUN);
            err_r      <= err_r | err_set_s;
            if (set_addr_s) begin
                addr_r <= set_val_s;
            end else if (ack_s) begin
                addr_r <= addr_r + ADDR_W'(1);
            end
            if (ack_s && (words_r != FULL_CNT)) begin
                words_r <= words_r + (ADDR_W + 1)'(1);
            end
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] sum_r;

    // Modulo-256 sum of transferred DATA bytes, restarted by SETADDR
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_r <= 8'd0;
        end else if (xfer_s && (in_cmd == CMD_SETADDR)) begin
            sum_r <= 8'd0;
        end else if (xfer_s && (in_cmd == CMD_DATA)) begin
            sum_r <= sum_r + in_data;
        end
    end

    assign checksum = sum_r;
`else
    assign checksum = 8'd0;
`endif

    assign in_ready     = in_ready_r;
    assign mem_we       = mem_we_r;
    assign mem_addr     = addr_r;
    assign mem_wdata    = word_s;
    assign cpu_run      = cpu_run_r;
    assign words_loaded = words_r;
    assign err_overrun  = err_r;

endmodule

// File: tb/tb_prog_loader.sv
// Directed scoreboard bench for prog_loader (INST_W=16, DEPTH=128).
module tb_prog_loader;
    import prog_loader_pkg::*;

    localparam int INST_W = 16;
    localparam int DEPTH  = 128;
    localparam int ADDR_W = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [1:0]        in_cmd;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [INST_W-1:0] mem_wdata;
    logic              mem_ready;
    logic              cpu_run;
    logic [ADDR_W:0]   words_loaded;
    logic              err_overrun;
    logic [7:0]        checksum;

    prog_loader #(.INST_W(INST_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_cmd       (in_cmd),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ready    (mem_ready),
        .cpu_run      (cpu_run),
        .words_loaded (words_loaded),
        .err_overrun  (err_overrun),
        .checksum     (checksum)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [INST_W-1:0] data;
    } wr_t;

    wr_t               sb_q[$];
    logic [ADDR_W-1:0] exp_addr;
    logic [7:0]        exp_sum;
    int                checks = 0;
    int                errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every acknowledged write must match the oldest expected write
    always @(negedge clk) begin
        if (rst === 1'b0 && mem_we === 1'b1 && mem_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_write observed addr=%0h data=%0h expected no write",
                       mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = sb_q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(e.addr));
                check("wr_data", 32'(mem_wdata), 32'(e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] c, input logic [7:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_cmd   = c;
        in_data  = d;
        while (in_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            check("in_ready_timeout", 32'(in_ready), 32'd1);
        end else begin
            tick();
            if (c == CMD_DATA) exp_sum = exp_sum + d;
            if (c == CMD_SETADDR) exp_sum = 8'd0;
        end
        in_valid = 1'b0;
    endtask

    task automatic set_addr(input logic [7:0] a);
        send(CMD_SETADDR, a);
        exp_addr = a[ADDR_W-1:0];
    endtask

    task automatic write_word(input logic [15:0] w);
        wr_t e;
        e.addr = exp_addr;
        e.data = w;
        sb_q.push_back(e);
        exp_addr = exp_addr + 7'd1;
        send(CMD_DATA, w[7:0]);
        send(CMD_DATA, w[15:8]);
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_cpu_run", 32'(cpu_run), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        check("rst_err", 32'(err_overrun), 32'd0);
        check("rst_checksum", 32'(checksum), 32'd0);
        sb_q.delete();
        exp_addr = 7'd0;
        exp_sum  = 8'd0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("in_ready_after_rst", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_cmd    = 2'b00;
        in_data   = 8'h00;
        mem_ready = 1'b1;
        exp_addr  = 7'd0;
        exp_sum   = 8'd0;
        tick();
        do_reset();

        // Reset in the middle of a partial word
        send(CMD_DATA, 8'h77);
        do_reset();

        // Basic write and latency
        set_addr(8'h05);
        write_word(16'h1234);
        check("basic_we", 32'(mem_we), 32'd1);
        check("basic_addr", 32'(mem_addr), 32'h05);
        check("basic_wdata", 32'(mem_wdata), 32'h1234);
        check("basic_in_ready", 32'(in_ready), 32'd0);
        tick();
        check("basic_we_low", 32'(mem_we), 32'd0);
        check("basic_words", 32'(words_loaded), 32'd1);
        write_word(16'hBEEF);
        check("second_addr", 32'(mem_addr), 32'h06);
        tick();
        check("second_words", 32'(words_loaded), 32'd2);

        // Backpressure: three stalled cycles then acknowledge
        mem_ready = 1'b0;
        write_word(16'hCAFE);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) mem_ready = 1'b1;
            check("bp_we", 32'(mem_we), 32'd1);
            check("bp_addr", 32'(mem_addr), 32'h07);
            check("bp_wdata", 32'(mem_wdata), 32'hCAFE);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        check("bp_done_we", 32'(mem_we), 32'd0);
        check("bp_words", 32'(words_loaded), 32'd3);

        // Address wrap at the top of memory
        set_addr(8'h7F);
        write_word(16'h7F7F);
        tick();
        write_word(16'h0101);
        check("wrap_addr", 32'(mem_addr), 32'h00);
        tick();
        check("wrap_words", 32'(words_loaded), 32'd5);

        // Counter saturation over 129 writes
        do_reset();
        for (int i = 0; i < 129; i++) begin
            write_word(16'(i * 3 + 1));
            if (i == 127) begin
                tick();
                check("sat_words_128", 32'(words_loaded), 32'd128);
            end
        end
        tick();
        tick();
        check("sat_words_129", 32'(words_loaded), 32'd128);

        // Run control and overrun error
        do_reset();
        send(CMD_DATA, 8'hAA);
        send(CMD_RUN, 8'h00);
        check("run_we", 32'(mem_we), 32'd0);
        check("run_cpu", 32'(cpu_run), 32'd1);
        send(CMD_DATA, 8'h55);
        check("run_err", 32'(err_overrun), 32'd1);
        check("run_cpu_kept", 32'(cpu_run), 32'd1);
        send(CMD_HALT, 8'h00);
        check("halt_cpu", 32'(cpu_run), 32'd0);
        check("halt_err_sticky", 32'(err_overrun), 32'd1);
        write_word(16'h2211);
        tick();
        check("after_run_words", 32'(words_loaded), 32'd1);
        check("after_run_err", 32'(err_overrun), 32'd1);

        // Checksum
        do_reset();
        set_addr(8'h00);
        write_word(16'h9080);
`ifdef PROG_LOADER_CHECKSUM_EN
        check("checksum", 32'(checksum), 32'h10);
`else
        check("checksum", 32'(checksum), 32'h00);
`endif
        check("checksum_model", 32'(checksum),
`ifdef PROG_LOADER_CHECKSUM_EN
              32'(exp_sum));
`else
              32'd0);
`endif
        tick();
        tick();

        // Reset while a write is stalled aborts it
        mem_ready = 1'b0;
        write_word(16'hABCD);
        check("abort_we", 32'(mem_we), 32'd1);
        do_reset();
        mem_ready = 1'b1;
        tick();
        tick();
        check("abort_words", 32'(words_loaded), 32'd0);
        check("abort_we_low", 32'(mem_we), 32'd0);

        tick();
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
